// File: rtl/counter_nb.sv
// Cascadable modulo-MOD up/down counter with synchronous clear/load,
// carry-in/ripple-carry chaining and a sticky wrap flag.
module counter_nb #(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ci,
  input  logic             up,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             rc,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             step_c;
  logic             term_c;

  assign step_c = en & ci;
  assign term_c = up ? (q_q == MAX_VAL) : (q_q == '0);

  // Terminal count and carry are combinational so a chain wraps on one edge.
  assign tc = term_c;
  assign rc = step_c & term_c;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = (64'(d) >= MOD) ? MAX_VAL : d;
    end else if (step_c) begin
      if (up) begin
        q_d = term_c ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = term_c ? MAX_VAL : q_q - WIDTH'(1);
      end
    end
  end

  // A wrap on the same cycle as ovf_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (rc && !clr && !ld) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_nb.sv
// Bench for counter_nb: directed test-plan steps followed by random stimulus,
// all checked against an arithmetic modulo reference model.
module tb_counter_nb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // A: default MOD=16; B: MOD=10 units digit; T: MOD=10 tens digit fed by B.rc
  logic       a_en, a_ci, a_up, a_clr, a_ld, a_oc;
  logic [3:0] a_d, a_q;
  logic       a_rc, a_tc, a_ovf;
  logic       b_en, b_ci, b_up, b_clr, b_ld, b_oc;
  logic [3:0] b_d, b_q;
  logic       b_rc, b_tc, b_ovf;
  logic       t_en, t_up, t_clr, t_ld, t_oc;
  logic [3:0] t_d, t_q;
  logic       t_rc, t_tc, t_ovf;

  counter_nb #(.WIDTH(4), .MOD(16)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .ci(a_ci), .up(a_up), .clr(a_clr),
    .ld(a_ld), .d(a_d), .ovf_clr(a_oc), .q(a_q), .rc(a_rc), .tc(a_tc), .ovf(a_ovf));
  counter_nb #(.WIDTH(4), .MOD(10)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .ci(b_ci), .up(b_up), .clr(b_clr),
    .ld(b_ld), .d(b_d), .ovf_clr(b_oc), .q(b_q), .rc(b_rc), .tc(b_tc), .ovf(b_ovf));
  counter_nb #(.WIDTH(4), .MOD(10)) u_t (
    .clk(clk), .rst_n(rst_n), .en(t_en), .ci(b_rc), .up(t_up), .clr(t_clr),
    .ld(t_ld), .d(t_d), .ovf_clr(t_oc), .q(t_q), .rc(t_rc), .tc(t_tc), .ovf(t_ovf));

  int errors = 0;
  int checks = 0;
  int ma_q, ma_ovf, mb_q, mb_ovf, mt_q, mt_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mterm(input int modv, input int qv, input bit upv);
    return upv ? int'(qv == modv - 1) : int'(qv == 0);
  endfunction

  // Next state from the counting rules, with modulo arithmetic.
  task automatic mnext(input int modv, input int qv, input int ov, input bit en_v,
                       input bit ci_v, input bit up_v, input bit clr_v, input bit ld_v,
                       input int d_v, input bit oc_v, output int nq, output int novf);
    int rcv;
    rcv = (en_v && ci_v) ? mterm(modv, qv, up_v) : 0;
    if (clr_v)             nq = 0;
    else if (ld_v)         nq = (d_v > modv - 1) ? modv - 1 : d_v;
    else if (en_v && ci_v) nq = up_v ? (qv + 1) % modv : (qv + modv - 1) % modv;
    else                   nq = qv;
    if (rcv != 0 && !clr_v && !ld_v) novf = 1;
    else if (oc_v)                   novf = 0;
    else                             novf = ov;
  endtask

  task automatic chk_comb();
    int brc;
    brc = (b_en && b_ci) ? mterm(10, mb_q, b_up) : 0;
    chk("a_tc", 32'(a_tc), 32'(mterm(16, ma_q, a_up)));
    chk("a_rc", 32'(a_rc), (a_en && a_ci) ? 32'(mterm(16, ma_q, a_up)) : 32'd0);
    chk("b_tc", 32'(b_tc), 32'(mterm(10, mb_q, b_up)));
    chk("b_rc", 32'(b_rc), 32'(brc));
    chk("t_tc", 32'(t_tc), 32'(mterm(10, mt_q, t_up)));
    chk("t_rc", 32'(t_rc), (t_en && brc != 0) ? 32'(mterm(10, mt_q, t_up)) : 32'd0);
  endtask

  task automatic chk_seq();
    chk("a_q", 32'(a_q), 32'(ma_q));
    chk("a_ovf", 32'(a_ovf), 32'(ma_ovf));
    chk("b_q", 32'(b_q), 32'(mb_q));
    chk("b_ovf", 32'(b_ovf), 32'(mb_ovf));
    chk("t_q", 32'(t_q), 32'(mt_q));
    chk("t_ovf", 32'(t_ovf), 32'(mt_ovf));
  endtask

  // One clock: check combinational outputs, advance model at the edge, check state.
  task automatic tick();
    int na, nao, nb, nbo, nt, nto, brc;
    #1;
    chk_comb();
    brc = (b_en && b_ci) ? mterm(10, mb_q, b_up) : 0;
    mnext(16, ma_q, ma_ovf, a_en, a_ci, a_up, a_clr, a_ld, int'(a_d), a_oc, na, nao);
    mnext(10, mb_q, mb_ovf, b_en, b_ci, b_up, b_clr, b_ld, int'(b_d), b_oc, nb, nbo);
    mnext(10, mt_q, mt_ovf, t_en, brc != 0, t_up, t_clr, t_ld, int'(t_d), t_oc, nt, nto);
    @(posedge clk);
    ma_q = na; ma_ovf = nao; mb_q = nb; mb_ovf = nbo; mt_q = nt; mt_ovf = nto;
    #1;
    chk_seq();
  endtask

  task automatic model_reset();
    ma_q = 0; ma_ovf = 0; mb_q = 0; mb_ovf = 0; mt_q = 0; mt_ovf = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1; a_ci = 1; a_up = 1; a_clr = 0; a_ld = 0; a_d = 0; a_oc = 0;
    b_en = 0; b_ci = 1; b_up = 0; b_clr = 0; b_ld = 0; b_d = 0; b_oc = 0;
    t_en = 0; t_up = 1; t_clr = 0; t_ld = 0; t_d = 0; t_oc = 0;
    model_reset();

    // Reset held for three cycles while enabled
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_a_q", 32'(a_q), 32'd0);
      chk("rst_a_ovf", 32'(a_ovf), 32'd0);
    end
    chk("rst_a_tc_up", 32'(a_tc), 32'd0);
    chk("rst_b_tc_down", 32'(b_tc), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Count 0..15,0 with wrap setting ovf
    repeat (17) tick();
    chk("wrap_a_ovf", 32'(a_ovf), 32'd1);

    // Modulo-10 down count from load 3, then saturating load
    b_ld = 1; b_d = 4'd3; tick();
    chk("ld3_b_q", 32'(b_q), 32'd3);
    b_ld = 0; b_en = 1; b_up = 0;
    repeat (5) tick();
    chk("down_b_q", 32'(b_q), 32'd8);
    b_en = 0; b_ld = 1; b_d = 4'd12; tick();
    chk("sat_b_q", 32'(b_q), 32'd9);
    b_ld = 0;

    // Priority: clr over ld over step, then ci=0 holds
    a_en = 0; a_ld = 1; a_d = 4'd7; tick();
    a_en = 1; a_ci = 1; a_clr = 1; a_ld = 1; a_d = 4'd5; tick();
    chk("prio_clr", 32'(a_q), 32'd0);
    a_clr = 0; tick();
    chk("prio_ld", 32'(a_q), 32'd5);
    a_ld = 0; a_ci = 0; tick();
    chk("hold_ci0", 32'(a_q), 32'd5);

    // Two-digit BCD cascade through 100 counts
    b_clr = 1; t_clr = 1; b_oc = 1; t_oc = 1; tick();
    b_clr = 0; t_clr = 0; b_oc = 0; t_oc = 0;
    b_en = 1; b_ci = 1; b_up = 1; t_en = 1; t_up = 1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk("bcd", 32'(int'(t_q) * 10 + int'(b_q)), 32'(i % 100));
    end
    b_en = 0; t_en = 0;

    // ovf: set beats clear, clear alone, wrap under ld does not set
    a_ci = 1; a_en = 0; a_oc = 1; a_ld = 1; a_d = 4'd15; tick();
    chk("ovf_cleared", 32'(a_ovf), 32'd0);
    a_ld = 0; a_en = 1; a_up = 1; a_oc = 1; tick();
    chk("ovf_set_wins", 32'(a_ovf), 32'd1);
    a_en = 0; tick();
    chk("ovf_clr_only", 32'(a_ovf), 32'd0);
    a_oc = 0; a_ld = 1; a_d = 4'd15; tick();
    a_en = 1; a_d = 4'd3; tick();
    chk("ovf_ld_wrap", 32'(a_ovf), 32'd0);
    chk("ld_over_wrap", 32'(a_q), 32'd3);

    // Async reset mid-count with ovf set
    a_ld = 1; a_d = 4'd15; a_en = 0; tick();
    a_ld = 0; a_en = 1; tick();
    a_en = 0; a_ld = 1; a_d = 4'd11; tick();
    chk("pre_rst_q", 32'(a_q), 32'd11);
    chk("pre_rst_ovf", 32'(a_ovf), 32'd1);
    a_ld = 0; a_en = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", 32'(a_q), 32'd0);
    chk("async_ovf", 32'(a_ovf), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("resume_q", 32'(a_q), 32'd3);

    // Random stimulus on all three instances
    for (int i = 0; i < 300; i++) begin
      a_en = 1'($urandom); a_ci = 1'($urandom); a_up = 1'($urandom);
      a_clr = ($urandom_range(15) == 0); a_ld = ($urandom_range(7) == 0);
      a_d = 4'($urandom); a_oc = ($urandom_range(3) == 0);
      b_en = 1'($urandom); b_ci = 1'($urandom); b_up = 1'($urandom);
      b_clr = ($urandom_range(15) == 0); b_ld = ($urandom_range(7) == 0);
      b_d = 4'($urandom); b_oc = ($urandom_range(3) == 0);
      t_en = 1'($urandom); t_up = 1'($urandom);
      t_clr = ($urandom_range(15) == 0); t_ld = ($urandom_range(7) == 0);
      t_d = 4'($urandom); t_oc = ($urandom_range(3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_nb.md
# counter_nb

Parametrised, cascadable synchronous counter and the next generation of the team's fixed 4-bit ripple-carry counter. It adds configurable width and modulus, an up/down direction, synchronous load and clear, count enable with carry-in for chaining, and a sticky wrap flag. It sits in lab datapaths as a timebase, divider or event counter. Several instances chain via `ci`/`rc` to form wider or BCD counters.

## Interface
- `WIDTH`, 4: counter width in bits, 1..32.
- `MOD`, 16: count modulus, 2..2^WIDTH. The count runs 0..MOD-1. `MOD=10` gives a BCD digit.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `en`  in  1  count enable.
- `ci`  in  1  carry-in; counting requires `en & ci`. Tie to 1 when not cascaded.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `clr`  in  1  synchronous clear to 0.
- `ld`  in  1  synchronous load from `d`.
- `d`  in  WIDTH  load value.
- `ovf_clr`  in  1  synchronous clear of `ovf`.
- `q`  out  WIDTH  count value, registered.
- `rc`  out  1  ripple carry/borrow out, combinational.
- `tc`  out  1  terminal-count indicator, combinational.
- `ovf`  out  1  sticky wrap flag, registered.

## Operation
- Define `step = en & ci`.
- Define `term = up ? (q == MOD-1) : (q == 0)`.
- `tc = term`, independent of `en`/`ci`.
- `rc = step & term`. The next stage advances exactly when this stage wraps.
- Next-state priority, highest first:
  1. `clr`: `q <= 0`.
  2. `ld`: `q <= (d >= MOD) ? MOD-1 : d`. Out-of-range loads saturate.
  3. `step & up`: `q <= term ? 0 : q+1`.
  4. `step & !up`: `q <= term ? MOD-1 : q-1`.
  5. Otherwise hold.
- `clr` and `ld` ignore `en`/`ci`.
- `ovf`:
  - Set on any cycle where `rc=1` and neither `clr` nor `ld` is asserted.
  - `ovf_clr` clears it.
  - If set and clear coincide, set wins, so no wrap event is lost.
  - `clr`/`ld` do not affect `ovf`.
- Arithmetic is WIDTH bits, unsigned. `q` never holds a value ≥ MOD. When `MOD=2^WIDTH`, wrap equals natural overflow.
- Direction change mid-count takes effect on the next edge with no extra state. `term` re-evaluates immediately for the new direction.

## Timing
- `rst_n` low: `q=0` and `ovf=0` immediately, without waiting for `clk`.
  - `rc`/`tc` follow combinationally: `tc=1` if `up=0`, else 0.
- Deassertion of `rst_n` is synchronised by the integrating level. The first count is on the first rising edge with `rst_n` high.
- Latency:
  - `q` changes one edge after `step`/`ld`/`clr` is sampled.
  - `rc`/`tc` are zero-latency from `q`, `up`, `en`, `ci`.
- Cascade: stage k `ci` is driven by stage k-1 `rc`. All stages share `clk`. The whole chain wraps on the same edge, with a combinational path through all stages.
- Reset asserted mid-count aborts the count. No partial update is retained.

## Test plan
- Reset, default params, `en=ci=up=1`: hold `rst_n=0` 3 cycles, then release.
  - Required: `q=0` during reset.
  - After release, `q` steps 0,1,…,15,0.
  - `rc=1` only while `q=15`.
  - `ovf` rises on the edge `q` wraps 15→0.
- `MOD=10`, down count from load `d=3`: expect `q` = 3,2,1,0,9,8.
  - `rc=1` only at `q=0`.
  - Apply `ld` with `d=12`: expect `q=9` (saturated).
- Priority: assert `clr`, `ld` (`d=5`) and `step` together at `q=7`: expect `q=0`.
  - Then `ld`+`step` at `q=0`: expect `q=5`.
  - `en=1, ci=0`: `q` holds 5.
- Cascade two `MOD=10` instances (units `rc` drives tens `ci`), count up from 0 for 100 cycles.
  - Required: BCD 00…99, then 00.
  - Tens `rc=1` only at 99.
- `ovf` rules: wrap with `ovf_clr` asserted on the same cycle: expect `ovf=1`.
  - `ovf_clr` alone: expect `ovf=0` next edge.
  - Wrap while `ld` asserted: `ovf` not set.
- Async reset mid-count: at `q=11`, pulse `rst_n` low between clock edges.
  - Required: `q=0` and `ovf=0` before the next edge.
  - Count resumes from 0 after release.
